// File: rtl/mprj_wb_responder.sv
// Wishbone classic responder for the user-project mprj bus window.
// Holds NWORDS byte-writable scratch words plus a 3-bit IRQ block
// (STATUS / RAISE / ENABLE), with a programmable number of wait states
// inserted before each acknowledge.
module mprj_wb_responder #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter logic [31:0] ADR_MASK    = 32'hFFFF_F000,
    parameter int unsigned NWORDS      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [2:0]  hw_event_i,
    output logic [2:0]  user_irq_o
);

    localparam int unsigned AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic [9:0]    adr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic [31:0]   scratch [NWORDS];
    logic [2:0]    status;
    logic [2:0]    enable;

    logic          start;
    logic          commit;
    logic          is_scr;
    logic          is_status;
    logic          is_raise;
    logic          is_enable;
    logic [AW-1:0] idx;
    logic [2:0]    w1c;
    logic [2:0]    raise;
    logic [31:0]   rd_data;

    // Window hit, register decode of the latched word address, and read mux
    always_comb begin
        start     = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & ADR_MASK) == BASE_ADR);
        idx       = adr_q[AW-1:0];
        is_scr    = !adr_q[9];
        is_status = (adr_q == 10'h200);
        is_raise  = (adr_q == 10'h201);
        is_enable = (adr_q == 10'h202);
        commit    = (state == S_ACK) && we_q;
        w1c       = (commit && is_status && sel_q[0]) ? dat_q[2:0] : '0;
        raise     = (commit && is_raise  && sel_q[0]) ? dat_q[2:0] : '0;
        rd_data   = '0;
        if (is_scr) begin
            rd_data = scratch[idx];
        end else if (is_status) begin
            rd_data = {29'd0, status};
        end else if (is_enable) begin
            rd_data = {29'd0, enable};
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic and acknowledge
    always_comb begin
        state_nx  = state;
        wbs_ack_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_nx = S_IDLE;
                end else if (cnt == '0) begin
                    state_nx = S_ACK;
                end
            end
            S_ACK: begin
                wbs_ack_o = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Request capture, wait-state counter, and read data presented during ACK
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            cnt       <= '0;
            wbs_dat_o <= '0;
        end else begin
            wbs_dat_o <= '0;
            if (state == S_IDLE && start) begin
                adr_q <= wbs_adr_i[11:2];
                we_q  <= wbs_we_i;
                sel_q <= wbs_sel_i;
                dat_q <= wbs_dat_i;
                cnt   <= WAIT_STATES[3:0];
            end else if (state == S_WAIT && wbs_cyc_i && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            // dat_o is loaded on entry to ACK so it is valid exactly while ack is high
            if (state == S_WAIT && state_nx == S_ACK && !we_q) begin
                wbs_dat_o <= rd_data;
            end
        end
    end

    // Scratch words, byte-lane writes committed at the end of the ACK cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                scratch[i] <= '0;
            end
        end else if (commit && is_scr) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (sel_q[n]) begin
                    scratch[idx][8*n +: 8] <= dat_q[8*n +: 8];
                end
            end
        end
    end

    // IRQ block: set (event or RAISE) wins over write-1-to-clear; IRQ output registered
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            status     <= '0;
            enable     <= '0;
            user_irq_o <= '0;
        end else begin
            status     <= (status & ~w1c) | hw_event_i | raise;
            user_irq_o <= status & enable;
            if (commit && is_enable && sel_q[0]) begin
                enable <= dat_q[2:0];
            end
        end
    end

endmodule

// File: tb/tb_mprj_wb_responder.sv
// Scoreboard bench for mprj_wb_responder: stimulus pushes the expected
// ack data and ack cycle, a negedge monitor pops and compares on every ack.
module tb_mprj_wb_responder;

    localparam int unsigned NW   = 16;
    localparam int unsigned WS   = 1;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [2:0]  hw_event_i;
    logic [2:0]  user_irq_o;

    mprj_wb_responder #(
        .BASE_ADR    (BASE),
        .ADR_MASK    (32'hFFFF_F000),
        .NWORDS      (NW),
        .WAIT_STATES (WS)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .hw_event_i (hw_event_i),
        .user_irq_o (user_irq_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] dat;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model of the register file
    logic [31:0] m_scr [NW];
    logic [2:0]  m_status;
    logic [2:0]  m_enable;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NW); i++) m_scr[i] = '0;
        m_status = '0;
        m_enable = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] off);
        int unsigned w;
        w = int'(off) / 4;
        if (w < 512) return m_scr[w % NW];
        if (w == 512) return {29'd0, m_status};
        if (w == 514) return {29'd0, m_enable};
        return 32'd0;
    endfunction

    task automatic model_write(input logic [11:0] off, input logic [3:0] sel,
                               input logic [31:0] d, input logic [2:0] ev);
        int unsigned w;
        logic [2:0] clr;
        logic [2:0] set;
        w   = int'(off) / 4;
        clr = '0;
        set = '0;
        if (w < 512) begin
            for (int n = 0; n < 4; n++)
                if (sel[n]) m_scr[w % NW][8*n +: 8] = d[8*n +: 8];
        end else if (sel[0]) begin
            if (w == 512) clr = d[2:0];
            if (w == 513) set = d[2:0];
            if (w == 514) m_enable = d[2:0];
        end
        m_status = (m_status & ~clr) | ev | set;
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && wbs_ack_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack at cycle %0d required none", cyc_cnt);
            end else begin
                mon_e = sb.pop_front();
                check("ack_data", wbs_dat_o, mon_e.dat);
                check("ack_latency", cyc_cnt, mon_e.cyc);
            end
        end
    end

    task automatic bus_idle();
        wbs_cyc_i  = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_we_i   = 1'b0;
        wbs_sel_i  = '0;
        wbs_adr_i  = '0;
        wbs_dat_i  = '0;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] d);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = d;
    endtask

    // One in-window access; ev is applied to hw_event_i during the ACK (commit) cycle
    task automatic access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] d, input logic [2:0] ev);
        exp_t e;
        logic [11:0] off;
        logic [2:0] irq_old;
        logic [2:0] irq_new;
        bit got;
        off = adr[11:0];
        @(posedge clk); #1;
        drive(we, adr, sel, d);
        e.dat = we ? 32'd0 : model_read(off);
        e.cyc = cyc_cnt + 2 + WS;
        sb.push_back(e);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wbs_ack_o) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: adr=%h got no ack required ack", adr);
            sb.delete();
            bus_idle();
            return;
        end
        hw_event_i = ev;
        irq_old = m_status & m_enable;
        @(posedge clk); #1;
        bus_idle();
        hw_event_i = '0;
        if (we) model_write(off, sel, d, ev);
        else    m_status = m_status | ev;
        irq_new = m_status & m_enable;
        @(negedge clk);
        check("irq_hold", {29'd0, user_irq_o}, {29'd0, irq_old});
        @(negedge clk);
        check("irq_update", {29'd0, user_irq_o}, {29'd0, irq_new});
    endtask

    task automatic count_no_ack(input string name, input int n);
        int acks;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        check(name, acks, 0);
    endtask

    task automatic miss(input logic [31:0] adr, input logic we, input logic [31:0] d);
        @(posedge clk); #1;
        drive(we, adr, 4'hF, d);
        count_no_ack("miss_no_ack", 32);
        #1 bus_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] off;
        logic [31:0] adr;
        int r;

        rst = 1'b1;
        hw_event_i = '0;
        bus_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_irq", {29'd0, user_irq_o}, 32'd0);
        rst = 1'b0;

        // Basic write / read-back with latency
        access(1, BASE + 32'h4, 4'hF, 32'hDEAD_BEEF, 3'b000);
        access(0, BASE + 32'h4, 4'hF, 32'h0, 3'b000);

        // Byte lanes, aliasing, ignored adr[1:0]
        access(1, BASE + 32'h8, 4'hF, 32'hFFFF_FFFF, 3'b000);
        access(1, BASE + 32'h8, 4'b0101, 32'h1234_5678, 3'b000);
        access(0, BASE + 32'h8, 4'h0, 32'h0, 3'b000);
        access(0, BASE + 32'h8 + 4 * NW + 3, 4'hF, 32'h0, 3'b000);
        access(1, BASE + 32'h8, 4'h0, 32'h0BAD_0BAD, 3'b000);
        access(0, BASE + 32'h8, 4'hF, 32'h0, 3'b000);

        // Window misses leave state untouched
        miss(32'h3000_1000, 1'b1, 32'h5555_5555);
        miss(32'h2FFF_FFFC, 1'b1, 32'h6666_6666);
        access(0, BASE + 32'h4, 4'hF, 32'h0, 3'b000);
        access(0, BASE + 32'h7FC, 4'hF, 32'h0, 3'b000);

        // IRQ block: enable, raise, set-wins-over-clear, clear
        access(1, BASE + 32'h808, 4'hF, 32'h5, 3'b000);
        access(1, BASE + 32'h804, 4'hF, 32'h7, 3'b000);
        access(0, BASE + 32'h800, 4'hF, 32'h0, 3'b000);
        access(0, BASE + 32'h804, 4'hF, 32'h0, 3'b000);
        access(1, BASE + 32'h800, 4'hF, 32'h1, 3'b001);
        access(0, BASE + 32'h800, 4'hF, 32'h0, 3'b000);
        access(1, BASE + 32'h800, 4'hF, 32'h2, 3'b000);
        access(0, BASE + 32'h800, 4'hF, 32'h0, 3'b000);
        access(0, BASE + 32'h808, 4'hF, 32'h0, 3'b000);
        access(0, BASE + 32'h900, 4'hF, 32'h0, 3'b000);

        // Abort: drop cyc during WAIT on a write
        access(1, BASE + 32'hC, 4'hF, 32'hA5A5_0003, 3'b000);
        @(posedge clk); #1;
        drive(1'b1, BASE + 32'hC, 4'hF, 32'h1111_2222);
        @(posedge clk); #1;
        bus_idle();
        count_no_ack("abort_no_ack", 8);
        access(0, BASE + 32'hC, 4'hF, 32'h0, 3'b000);

        // Randomized traffic against the model
        for (int t = 0; t < 80; t++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                5:       off = 12'h800 | 12'($urandom_range(0, 3));
                6:       off = 12'h804 | 12'($urandom_range(0, 3));
                7:       off = 12'h808 | 12'($urandom_range(0, 3));
                8:       off = 12'($urandom_range(12'h80C, 12'hFFF));
                default: off = 12'($urandom_range(0, 12'h7FF));
            endcase
            if (r == 9 && t % 10 == 0) begin
                adr = $urandom;
                if ((adr & 32'hFFFF_F000) == BASE) adr = adr ^ 32'h0001_0000;
                miss(adr, 1'($urandom_range(0, 1)), $urandom);
            end else begin
                access(1'($urandom_range(0, 1)), BASE | {20'd0, off},
                       4'($urandom_range(0, 15)), $urandom,
                       ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
            end
        end

        // Reset asserted mid-WAIT
        access(1, BASE + 32'h808, 4'hF, 32'h7, 3'b000);
        access(1, BASE + 32'h804, 4'hF, 32'h7, 3'b000);
        access(1, BASE + 32'h14, 4'hF, 32'hCAFE_F00D, 3'b000);
        @(posedge clk); #1;
        drive(1'b1, BASE + 32'h14, 4'hF, 32'h1234_4321);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("midrst_irq", {29'd0, user_irq_o}, 32'd0);
        check("midrst_dat", wbs_dat_o, 32'd0);
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        access(0, BASE + 32'h14, 4'hF, 32'h0, 3'b000);
        access(0, BASE + 32'h4, 4'hF, 32'h0, 3'b000);
        access(0, BASE + 32'h800, 4'hF, 32'h0, 3'b000);
        access(0, BASE + 32'h808, 4'hF, 32'h0, 3'b000);

        repeat (5) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
